fetch_queue: RTL
================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter XLEN, default 32, the PC/address width.
REQ-002 SHALL have parameter DEPTH, default 4, the queue entry count; power of two, at least 2.
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address.
REQ-004 SHALL use one clock; reset SHALL be synchronous and active-high.
REQ-005 SHALL have port i_clk, input, 1 bit, the clock.
REQ-006 SHALL have port i_rst, input, 1 bit, the synchronous active-high reset.
REQ-007 SHALL have port i_pc_src_EX, input, 1 bit, the redirect request from EX.
REQ-008 SHALL have port i_pc_target_EX, input, XLEN bits, the redirect target.
REQ-009 SHALL have port o_imem_req, output, 1 bit, the instruction-memory read request.
REQ-010 SHALL have port o_imem_addr, output, XLEN bits, the request address.
REQ-011 SHALL have port i_imem_rdata, input, 32 bits, the read data, valid exactly one cycle after o_imem_req.
REQ-012 SHALL have port o_valid_F, output, 1 bit, meaning the head entry is available to decode.
REQ-013 SHALL have port i_ready_D, input, 1 bit, meaning decode accepts the head entry.
REQ-014 SHALL have ports o_pc_F (output, XLEN bits) and o_pc_plus4_F (output, XLEN bits), the head PC and head PC + 4.
REQ-015 SHALL have port o_instr_F, output, 32 bits, the head instruction.
REQ-016 SHALL have port o_count, output, $clog2(DEPTH+1) bits, the number of valid queue entries.

Function
REQ-017 SHALL keep a fetch PC register; o_imem_addr SHALL equal the fetch PC.
REQ-018 SHALL assert o_imem_req when count + inflight < DEPTH and i_pc_src_EX = 0; inflight is 1 while a response is pending.
REQ-019 SHALL advance the fetch PC by 4 on each request, wrapping modulo 2^XLEN.
REQ-020 SHALL capture the request PC into the inflight slot and, next cycle, enqueue {pc, i_imem_rdata} at the tail.
REQ-021 SHALL drive o_valid_F = (count != 0); o_pc_F/o_instr_F from the head; o_pc_plus4_F = head PC + 4, wrapping.
REQ-022 SHALL dequeue the head only on o_valid_F && i_ready_D; head outputs SHALL hold stable while o_valid_F && !i_ready_D.
REQ-023 SHALL leave count unchanged on a same-cycle enqueue and dequeue, advancing both pointers; pointers SHALL wrap at DEPTH.
REQ-024 SHALL, by the credit rule, never enqueue into a full queue and never deassert o_valid_F with entries present.
REQ-025 SHALL, on i_pc_src_EX = 1, clear the queue (count = 0), kill any inflight response (not enqueued), and load fetch PC with {i_pc_target_EX[XLEN-1:2], 2'b00}.
REQ-026 SHALL give redirect priority over same-cycle enqueue, dequeue, and request; the first target request SHALL issue the next cycle.
REQ-027 SHALL have redirect-to-output latency of 3 cycles: redirect in cycle R, request in R+1, data in R+2, o_valid_F in R+3.
REQ-028 SHALL handle back-to-back redirects with the last one taking effect.

Reset
REQ-029 SHALL, on i_rst = 1, set fetch PC = RESET_PC, count = 0, pointers = 0, inflight = 0.
REQ-030 SHALL hold o_imem_req = 0, o_valid_F = 0 and o_count = 0 during reset; data outputs are don't-care while o_valid_F = 0.
REQ-031 SHALL discard any in-flight response on reset mid-operation.
REQ-032 SHALL, from the first cycle after reset release (C0), request RESET_PC in C0 and assert o_valid_F in C2.

Structure
REQ-033 SHALL place XLEN default, RESET_PC default and the entry struct fetch_entry_t {pc, instr} in package fetch_pkg.
REQ-034 SHALL implement queue storage as sub-module sync_fifo (parametrised WIDTH/DEPTH, with a flush input); PC, credit and inflight logic SHALL stay in fetch_queue.

Verification
REQ-035 SHALL cover reset release with i_ready_D = 1 and imem returning addr-as-data: o_valid_F at C2 with o_pc_F = 0, o_pc_plus4_F = 4, then one entry per cycle at PCs 0, 4, 8, ...
REQ-036 SHALL cover i_ready_D = 0 for 10 cycles: o_count saturates at 4, o_imem_req = 0, and the head stays at PC 0 and stable.
REQ-037 SHALL cover redirect to 0x100 with the queue full and a response inflight: next cycle o_count = 0 and the stale response is dropped; o_pc_F = 0x100 three cycles after redirect.
REQ-038 SHALL cover redirect to 0x203: fetch proceeds from 0x200.
REQ-039 SHALL cover RESET_PC = 32'hFFFF_FFFC: PCs FFFF_FFFC, then 0000_0000, and o_pc_plus4_F = 0 for the first entry.
REQ-040 SHALL cover i_rst asserted mid-stream with 3 queued entries: next cycle o_count = 0 and o_valid_F = 0, and refetch starts from RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-queue definitions: default widths, reset PC and the queue entry layout.
package fetch_pkg;

    localparam int DEFAULT_XLEN = 32;
    localparam int INSTR_W      = 32;
    localparam logic [DEFAULT_XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [DEFAULT_XLEN-1:0] pc;
        logic [INSTR_W-1:0]      instr;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous reset and flush; head entry is shown combinationally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Guards make the FIFO safe even if a caller ignores its occupancy.
    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && ((count_q != CNT_W'(DEPTH)) || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: credit-gated imem requests, one-deep response tracking,
// and a FIFO of {pc, instr} entries handed to decode; EX redirects flush everything.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int              XLEN     = DEFAULT_XLEN,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_pc_src_EX,
    input  logic [XLEN-1:0]              i_pc_target_EX,
    output logic                         o_imem_req,
    output logic [XLEN-1:0]              o_imem_addr,
    input  logic [INSTR_W-1:0]           i_imem_rdata,
    output logic                         o_valid_F,
    input  logic                         i_ready_D,
    output logic [XLEN-1:0]              o_pc_F,
    output logic [XLEN-1:0]              o_pc_plus4_F,
    output logic [INSTR_W-1:0]           o_instr_F,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int ENTRY_W = XLEN + INSTR_W;
    localparam int CNT_W   = $clog2(DEPTH+1);

    logic [XLEN-1:0]    fetch_pc_q, fetch_pc_d;
    logic               inflight_q, inflight_d;
    logic [XLEN-1:0]    inflight_pc_q, inflight_pc_d;

    logic               req;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] head_data;
    logic [CNT_W-1:0]   fifo_count;

    // An outstanding response already owns a slot, so it counts against the credit.
    assign req  = !i_rst && !i_pc_src_EX
                  && ((int'(fifo_count) + int'(inflight_q)) < DEPTH);
    assign push = inflight_q && !i_pc_src_EX;
    assign pop  = (fifo_count != '0) && i_ready_D && !i_pc_src_EX;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = req;
        inflight_pc_d = inflight_pc_q;
        if (i_pc_src_EX) begin
            fetch_pc_d = {i_pc_target_EX[XLEN-1:2], 2'b00};
        end else if (req) begin
            fetch_pc_d    = fetch_pc_q + XLEN'(4);
            inflight_pc_d = fetch_pc_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (i_clk),
        .rst       (i_rst),
        .flush     (i_pc_src_EX),
        .push      (push),
        .push_data ({inflight_pc_q, i_imem_rdata}),
        .pop       (pop),
        .head_data (head_data),
        .count     (fifo_count)
    );

    assign o_imem_req   = req;
    assign o_imem_addr  = fetch_pc_q;
    assign o_valid_F    = !i_rst && (fifo_count != '0);
    assign o_count      = i_rst ? '0 : fifo_count;
    assign o_pc_F       = head_data[ENTRY_W-1:INSTR_W];
    assign o_instr_F    = head_data[INSTR_W-1:0];
    assign o_pc_plus4_F = o_pc_F + XLEN'(4);

endmodule
